// File: rtl/alu_compare_sweeper.sv
// Built-in self-test engine for the ALU subtract-and-flags path. It applies
// operand pairs with the operation fixed to Alu_Sub. For every pair it
// compares the ten integer relations derived from the returned flags against
// the true relations of the operands. Pairs come from an exhaustive counter or
// from a Galois LFSR. The result is a saturating error count, a pass flag and a
// capture of the first failing pair.

package pkg_cpu;
    typedef enum logic [3:0] {
        Alu_Add  = 4'd0,
        Alu_Sub  = 4'd1,
        Alu_And  = 4'd2,
        Alu_Or   = 4'd3,
        Alu_Xor  = 4'd4,
        Alu_Shl  = 4'd5,
        Alu_Shr  = 4'd6,
        Alu_Pass = 4'd7
    } alu_oper_t;

    localparam int ALU_OPER_W = $bits(alu_oper_t);

    // Bit positions inside the 4-bit ALU flag vector.
    localparam int FlagZ = 0;
    localparam int FlagC = 1;   // carry = no borrow on subtract (a >= b unsigned)
    localparam int FlagV = 2;
    localparam int FlagN = 3;
endpackage

module alu_compare_sweeper #(
    parameter int          WIDTH         = 8,
    parameter int          ALU_LATENCY   = 0,
    parameter logic [31:0] LFSR_TAPS     = 32'h0000_B400,
    parameter int          LFSR_COUNT    = 256,
    parameter int          ERR_CNT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            mode,
    input  logic [2*WIDTH-1:0]              seed,
    output logic [WIDTH-1:0]                alu_a,
    output logic [WIDTH-1:0]                alu_b,
    output logic [pkg_cpu::ALU_OPER_W-1:0]  alu_oper,
    output logic [3:0]                      alu_flags_in,
    input  logic [3:0]                      alu_flags_out,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [ERR_CNT_WIDTH-1:0]        err_count,
    output logic [WIDTH-1:0]                first_err_a,
    output logic [WIDTH-1:0]                first_err_b,
    output logic [9:0]                      first_err_mask
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (LFSR_COUNT > 1) ? $clog2(LFSR_COUNT) : 1;
    localparam int SET_W = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

    localparam logic [PW-1:0]            TAPS    = LFSR_TAPS[PW-1:0];
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK
    } state_t;

    state_t                     r_state;
    logic                       r_mode;
    logic [PW-1:0]              r_gen;       // current pair {a, b} or LFSR state
    logic [CNT_W-1:0]           r_left;      // random pairs remaining after this one
    logic [SET_W-1:0]           r_settle;
    logic [WIDTH-1:0]           r_alu_a;
    logic [WIDTH-1:0]           r_alu_b;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_pass;
    logic [ERR_CNT_WIDTH-1:0]   r_err_count;
    logic [WIDTH-1:0]           r_first_a;
    logic [WIDTH-1:0]           r_first_b;
    logic [9:0]                 r_first_mask;

    logic [PW-1:0]              w_gen_next;
    logic                       w_last;
    logic [9:0]                 w_expect;
    logic [9:0]                 w_predict;
    logic [9:0]                 w_mask;
    logic                       w_z, w_c, w_v, w_n, w_lt;

    assign alu_a          = r_alu_a;
    assign alu_b          = r_alu_b;
    assign alu_oper       = pkg_cpu::Alu_Sub;
    assign alu_flags_in   = 4'b0000;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err_count;
    assign first_err_a    = r_first_a;
    assign first_err_b    = r_first_b;
    assign first_err_mask = r_first_mask;

    // Next pair and end-of-run detection for the active generator.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_gen_next = r_gen + PW'(1);
        w_last     = (r_gen == '1);
        if (r_mode) begin
            w_gen_next = (r_gen >> 1) ^ (r_gen[0] ? TAPS : '0);
            w_last     = (r_left == '0);
        end
    end

    // True relations of the applied operands versus relations implied by the flags.
    always_comb begin
        w_z  = alu_flags_out[pkg_cpu::FlagZ];
        w_c  = alu_flags_out[pkg_cpu::FlagC];
        w_v  = alu_flags_out[pkg_cpu::FlagV];
        w_n  = alu_flags_out[pkg_cpu::FlagN];
        w_lt = w_n ^ w_v;

        w_expect[0] = (r_alu_a == r_alu_b);
        w_expect[1] = (r_alu_a != r_alu_b);
        w_expect[2] = (r_alu_a <  r_alu_b);
        w_expect[3] = (r_alu_a <= r_alu_b);
        w_expect[4] = (r_alu_a >  r_alu_b);
        w_expect[5] = (r_alu_a >= r_alu_b);
        w_expect[6] = ($signed(r_alu_a) <  $signed(r_alu_b));
        w_expect[7] = ($signed(r_alu_a) <= $signed(r_alu_b));
        w_expect[8] = ($signed(r_alu_a) >  $signed(r_alu_b));
        w_expect[9] = ($signed(r_alu_a) >= $signed(r_alu_b));

        w_predict[0] = w_z;
        w_predict[1] = !w_z;
        w_predict[2] = !w_c;
        w_predict[3] = !w_c | w_z;
        w_predict[4] = w_c & !w_z;
        w_predict[5] = w_c;
        w_predict[6] = w_lt;
        w_predict[7] = w_lt | w_z;
        w_predict[8] = !w_lt & !w_z;
        w_predict[9] = !w_lt;

        w_mask = w_expect ^ w_predict;
    end

    // Sweep control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_mode       <= 1'b0;
            r_gen        <= '0;
            r_left       <= '0;
            r_settle     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_first_a    <= '0;
            r_first_b    <= '0;
            r_first_mask <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_done <= 1'b0;
            if (r_state != S_IDLE && abort) begin
                // Abort keeps the error record; pass stays cleared from start.
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_mode       <= mode;
                            r_gen        <= mode ? ((seed == '0) ? PW'(1) : seed) : '0;
                            r_left       <= CNT_W'(LFSR_COUNT - 1);
                            r_err_count  <= '0;
                            r_first_a    <= '0;
                            r_first_b    <= '0;
                            r_first_mask <= '0;
                            r_pass       <= 1'b0;
                            r_busy       <= 1'b1;
                            r_state      <= S_APPLY;
                        end
                    end
                    S_APPLY: begin
                        r_alu_a  <= r_gen[PW-1:WIDTH];
                        r_alu_b  <= r_gen[WIDTH-1:0];
                        r_settle <= SET_W'((ALU_LATENCY > 0) ? ALU_LATENCY - 1 : 0);
                        r_state  <= (ALU_LATENCY == 0) ? S_CHECK : S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (r_settle == '0) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_settle <= r_settle - SET_W'(1);
                        end
                    end
                    S_CHECK: begin
                        if (w_mask != '0) begin
                            // A zero count means no failure yet in this run.
                            if (r_err_count == '0) begin
                                r_first_a    <= r_alu_a;
                                r_first_b    <= r_alu_b;
                                r_first_mask <= w_mask;
                            end
                            if (r_err_count != ERR_MAX) begin
                                r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
                            end
                        end
                        r_gen <= w_gen_next;
                        if (r_mode) begin
                            r_left <= r_left - CNT_W'(1);
                        end
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (r_err_count == '0) && (w_mask == '0);
                        end else begin
                            r_state <= S_APPLY;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_compare_sweeper.sv
// Self-checking bench for alu_compare_sweeper: a pipelined behavioural ALU with
// fault injection feeds the DUT; a reference model built from the compare rules
// predicts the pair sequence, error count and first-failure capture.

module tb_alu_compare_sweeper;
    import pkg_cpu::*;

    localparam int          W    = 4;
    localparam int          L    = 2;
    localparam int          CNT  = 40;
    localparam int          EW   = 4;
    localparam logic [31:0] TAPS = 32'h0000_00B8;
    localparam int          PW   = 2 * W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               mode = 1'b0;
    logic [PW-1:0]      seed = '0;
    logic [W-1:0]       alu_a, alu_b;
    logic [ALU_OPER_W-1:0] alu_oper;
    logic [3:0]         alu_flags_in, alu_flags_out;
    logic               busy, done, pass;
    logic [EW-1:0]      err_count;
    logic [W-1:0]       first_err_a, first_err_b;
    logic [9:0]         first_err_mask;

    // Fault injection for the behavioural ALU.
    logic               fault_zero = 1'b0;
    logic [W-1:0]       fault_a = '0, fault_b = '0;
    logic [3:0]         fault_xor = 4'b0000;

    logic [3:0]         pipe [L];

    int n_checks = 0;
    int n_errors = 0;

    logic [PW-1:0]      pairs[$];
    int                 exp_err;
    logic [W-1:0]       exp_fa, exp_fb;
    logic [9:0]         exp_fm;
    logic [PW-1:0]      obs_first;

    alu_compare_sweeper #(
        .WIDTH(W), .ALU_LATENCY(L), .LFSR_TAPS(TAPS),
        .LFSR_COUNT(CNT), .ERR_CNT_WIDTH(EW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .seed(seed), .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper),
        .alu_flags_in(alu_flags_in), .alu_flags_out(alu_flags_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_a(first_err_a), .first_err_b(first_err_b),
        .first_err_mask(first_err_mask)
    );

    always #5 clk = ~clk;

    function automatic int to_signed(input int u);
        return (u >= (1 << (W - 1))) ? u - (1 << W) : u;
    endfunction

    // Behavioural subtract flags, with optional injected faults.
    function automatic logic [3:0] alu_flags(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [3:0] f;
        int ua, ub, diff, sdiff;
        ua = int'(a);
        ub = int'(b);
        diff  = (ua - ub + (1 << W)) % (1 << W);
        sdiff = to_signed(ua) - to_signed(ub);
        f = 4'b0000;
        f[FlagZ] = (diff == 0);
        f[FlagC] = (ua >= ub);
        f[FlagN] = (diff >= (1 << (W - 1)));
        f[FlagV] = (sdiff > (1 << (W - 1)) - 1) || (sdiff < -(1 << (W - 1)));
        if (fault_zero) f = 4'b0000;
        else if (a == fault_a && b == fault_b) f = f ^ fault_xor;
        return f;
    endfunction

    // ALU pipeline: flags valid L cycles after the operands change.
    always @(posedge clk) begin
        pipe[0] <= alu_flags(alu_a, alu_b);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign alu_flags_out = pipe[L-1];

    // Expected-versus-flag-derived relation mismatch for one pair.
    function automatic logic [9:0] ref_mask(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [3:0] f;
        logic [9:0] e, p;
        logic z, c, lt;
        int ua, ub, sa, sb;
        f  = alu_flags(a, b);
        z  = f[FlagZ];
        c  = f[FlagC];
        lt = f[FlagN] ^ f[FlagV];
        ua = int'(a);
        ub = int'(b);
        sa = to_signed(ua);
        sb = to_signed(ub);
        e = {sa >= sb, sa > sb, sa <= sb, sa < sb,
             ua >= ub, ua > ub, ua <= ub, ua < ub, ua != ub, ua == ub};
        p = {!lt, !lt & !z, lt | z, lt,
             c, c & !z, !c | z, !c, !z, z};
        return e ^ p;
    endfunction

    task automatic build_pairs(input logic m, input logic [PW-1:0] s);
        int unsigned st;
        int unsigned lsb;
        pairs.delete();
        if (!m) begin
            for (int a = 0; a < (1 << W); a++)
                for (int b = 0; b < (1 << W); b++)
                    pairs.push_back({W'(a), W'(b)});
        end else begin
            st = (s == '0) ? 1 : int'(s);
            for (int i = 0; i < CNT; i++) begin
                pairs.push_back(PW'(st));
                lsb = st & 1;
                st  = st >> 1;
                if (lsb != 0) st = st ^ TAPS;
            end
        end
    endtask

    task automatic score(input int n);
        logic [PW-1:0] p;
        logic [9:0] m;
        exp_err = 0;
        exp_fa = '0;
        exp_fb = '0;
        exp_fm = '0;
        for (int i = 0; i < n; i++) begin
            p = pairs[i];
            m = ref_mask(p[PW-1:W], p[W-1:0]);
            if (m != '0) begin
                if (exp_err == 0) begin
                    exp_fa = p[PW-1:W];
                    exp_fb = p[W-1:0];
                    exp_fm = m;
                end
                if (exp_err < (1 << EW) - 1) exp_err++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m, input logic [PW-1:0] s);
        mode  = m;
        seed  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Full run: every applied pair, the done timing and the final record.
    task automatic run_full(input logic m, input logic [PW-1:0] s, input string tag);
        int per, total, bad, early;
        per = L + 2;
        build_pairs(m, s);
        score(pairs.size());
        total = pairs.size() * per;
        bad = 0;
        early = 0;
        do_start(m, s);
        for (int c = 1; c <= total; c++) begin
            tick();
            if (c == 1) begin
                check({tag, "/busy"}, 32'(busy), 32'd1);
                check({tag, "/pass_clr"}, 32'(pass), 32'd0);
            end
            if ((c - 1) % per == 0) begin
                if (c == 1) obs_first = {alu_a, alu_b};
                if ({alu_a, alu_b} !== pairs[(c - 1) / per]) bad++;
            end
            if (c < total && done) early++;
        end
        check({tag, "/pairs"}, 32'(bad), 32'd0);
        check({tag, "/early_done"}, 32'(early), 32'd0);
        check({tag, "/done"}, 32'(done), 32'd1);
        check({tag, "/err_count"}, 32'(err_count), 32'(exp_err));
        check({tag, "/pass"}, 32'(pass), 32'(exp_err == 0));
        check({tag, "/first"}, {first_err_a, first_err_b, first_err_mask},
              {exp_fa, exp_fb, exp_fm});
        tick();
        check({tag, "/done_pulse"}, 32'(done), 32'd0);
        check({tag, "/busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int idx;
        int early;
        logic [PW-1:0] p;
        logic [PW-1:0] rs;

        // Reset state.
        #12;
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/done", 32'(done), 32'd0);
        check("rst/pass", 32'(pass), 32'd0);
        check("rst/err_count", 32'(err_count), 32'd0);
        check("rst/operands", {alu_a, alu_b}, 32'd0);
        check("rst/first", {first_err_a, first_err_b, first_err_mask}, 32'd0);
        check("rst/oper", 32'(alu_oper), 32'(Alu_Sub));
        check("rst/flags_in", 32'(alu_flags_in), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Correct ALU, exhaustive sweep.
        run_full(1'b0, '0, "exh_ok");

        // Carry inverted only at (3,5): single error, mask 0x03C.
        fault_a = W'(3);
        fault_b = W'(5);
        fault_xor = 4'(1 << FlagC);
        run_full(1'b0, '0, "exh_c35");
        check("exh_c35/mask_const", 32'(first_err_mask), 32'h03C);

        // Random mode, seed 0 fixed up to 1.
        fault_xor = 4'b0000;
        run_full(1'b1, '0, "rnd_seed0");
        check("rnd_seed0/first_pair", 32'(obs_first), 32'h01);

        // Random seeds with a random fault on a pair the run visits.
        for (int k = 0; k < 3; k++) begin
            rs = PW'($urandom);
            build_pairs(1'b1, rs);
            idx = $urandom_range(0, CNT - 1);
            p = pairs[idx];
            fault_a = p[PW-1:W];
            fault_b = p[W-1:0];
            fault_xor = 4'($urandom_range(1, 15));
            run_full(1'b1, rs, "rnd_fault");
        end

        // Exhaustive sweep with a random fault.
        fault_a = W'($urandom);
        fault_b = W'($urandom);
        fault_xor = 4'($urandom_range(1, 15));
        run_full(1'b0, '0, "exh_fault");

        // Flags stuck at zero: the error counter saturates.
        fault_xor = 4'b0000;
        fault_zero = 1'b1;
        run_full(1'b0, '0, "exh_zero");
        check("exh_zero/sat", 32'(err_count), 32'hF);

        // Abort while applying pair 20.
        build_pairs(1'b0, '0);
        score(20);
        do_start(1'b0, '0);
        repeat (20 * (L + 2)) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/done", 32'(done), 32'd0);
        check("abort/err_count", 32'(err_count), 32'(exp_err));
        check("abort/first", {first_err_a, first_err_b, first_err_mask},
              {exp_fa, exp_fb, exp_fm});
        check("abort/pass", 32'(pass), 32'd0);
        early = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done) early++;
        end
        check("abort/no_done", 32'(early), 32'd0);

        // Asynchronous reset mid-run, then a clean run.
        do_start(1'b0, '0);
        repeat (30) tick();
        check("rst_mid/pre_err", 32'(err_count != '0), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid/busy", 32'(busy), 32'd0);
        check("rst_mid/done", 32'(done), 32'd0);
        check("rst_mid/err_count", 32'(err_count), 32'd0);
        check("rst_mid/operands", {alu_a, alu_b}, 32'd0);
        check("rst_mid/first", {first_err_a, first_err_b, first_err_mask}, 32'd0);
        tick();
        rst_n = 1'b1;
        fault_zero = 1'b0;
        tick();
        run_full(1'b0, '0, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_compare_sweeper.md
Name: alu_compare_sweeper

Overview:
- Synthesizable, self-checking stimulus engine for the ALU's subtract-and-flags path.
- Drives an Alu instance with operand pairs and sets the operation to Alu_Sub.
- Checks the returned flags against all ten integer compare relations and reports pass/fail plus first-failure capture.
- Generalises the exhaustive compare sweep: parametrised width and ALU latency, plus an LFSR random mode for widths where an exhaustive sweep is impractical. Used in simulation and as an on-FPGA built-in self-test.

Parameters:
- WIDTH, 8: operand width in bits; legal range 2..16.
- ALU_LATENCY, 0: clock cycles from operands changing to alu_flags_out valid.
- LFSR_TAPS, 16'hB400: Galois feedback mask for the 2*WIDTH-bit LFSR. Must be maximal-length for 2*WIDTH.
- LFSR_COUNT, 256: number of pairs checked in random mode; must be at least 1.
- ERR_CNT_WIDTH, 16: width of the error counter.

Ports:
- clk, input, 1: the single clock.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begins a run when sampled high in IDLE.
- abort, input, 1: terminates a run.
- mode, input, 1: 0 = exhaustive, 1 = random; sampled with start.
- seed, input, 2*WIDTH: LFSR seed; sampled with start.
- alu_a, output, WIDTH: operand a to the ALU, registered.
- alu_b, output, WIDTH: operand b to the ALU, registered.
- alu_oper, output, ALU oper enum width: constant Alu_Sub.
- alu_flags_in, output, 4: constant 4'b0000.
- alu_flags_out, input, 4: flags from the ALU, indexed by pkg_cpu FlagZ/FlagC/FlagV/FlagN.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle pulse when a run completes.
- pass, output, 1: high when err_count==0; valid from the done pulse until the next start.
- err_count, output, ERR_CNT_WIDTH: number of failing pairs; saturates.
- first_err_a, output, WIDTH: operand a of the first failing pair.
- first_err_b, output, WIDTH: operand b of the first failing pair.
- first_err_mask, output, 10: mismatching relations of the first failing pair.

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output register is 0 (alu_a, alu_b, busy, done, pass, err_count, first_err_*).
  - alu_oper is constant Alu_Sub; alu_flags_in is constant 4'b0000.
  - Reset mid-run discards everything; no done pulse.
- FSM states: IDLE, APPLY, SETTLE, CHECK.
- IDLE:
  - On start=1, latch mode. Clear err_count, first_err_*, pass, and the first-error flag.
  - Exhaustive: the pair generator is set to (0,0).
  - Random: the LFSR is loaded with seed; seed==0 is replaced by 1.
  - Go to APPLY.
- APPLY (1 cycle): alu_a and alu_b load the current pair at the exit edge. Then go to SETTLE, or straight to CHECK when ALU_LATENCY==0.
- SETTLE: stays exactly ALU_LATENCY cycles, then goes to CHECK.
- CHECK (1 cycle): sample alu_flags_out and compute expected results from alu_a and alu_b.
  - Mask bit order: [0] eq, [1] ne, [2] ult, [3] ule, [4] ugt, [5] uge, [6] slt, [7] sle, [8] sgt, [9] sge.
  - Predicted results from flags:
    - eq: Z; ne: !Z.
    - ult: !C; ule: !C|Z; ugt: C&!Z; uge: C.
    - slt: N!=V; sle: (N!=V)|Z; sgt: (N==V)&!Z; sge: N==V.
  - Expected results: true compares of the operands (unsigned, or signed two's complement, WIDTH bits).
  - Mismatch mask = expected XOR predicted. A nonzero mask increments err_count once, saturating at all-ones.
  - On the first nonzero mask: capture alu_a, alu_b and the mask.
  - Advance the generator and go to APPLY; after the last pair, go to IDLE and pulse done.
- Cost: ALU_LATENCY+2 cycles per pair.
- Exhaustive generator:
  - b is the inner loop, a the outer; both wrap at 2^WIDTH.
  - The last pair is (2^WIDTH-1, 2^WIDTH-1); 2^(2*WIDTH) pairs in total.
- Random generator:
  - Pair = {a = LFSR upper WIDTH bits, b = lower WIDTH bits}.
  - The first pair is the (fixed-up) seed.
  - Step: Galois shift right, then XOR LFSR_TAPS if the shifted-out bit was 1.
  - Exactly LFSR_COUNT pairs.
- done asserts in the cycle after the final CHECK. pass = (err_count==0) is registered on the same edge.
- abort=1 in any non-IDLE state: go to IDLE at the next edge.
  - No done pulse; err_count and first_err_* keep their values; pass stays 0.
  - abort has priority over start.
  - start while busy is ignored.

Test Plan:
1. Correct reference ALU model, WIDTH=4, ALU_LATENCY=0, exhaustive mode, start pulse -> done pulses 512 cycles after APPLY is first entered; err_count=0, pass=1, busy low the cycle after done.
2. Same setup with FlagC inverted only when a=3, b=5 -> err_count=1, first_err_a=3, first_err_b=5, first_err_mask=10'h03C, pass=0.
3. Random mode, WIDTH=8, seed=0, LFSR_COUNT=16 -> first applied pair a=8'h00, b=8'h01; 16 CHECK cycles, then done; pairs match a software Galois model with taps 16'hB400.
4. ALU_LATENCY=2 with a two-stage pipelined ALU model, WIDTH=4 exhaustive -> err_count=0; done 1024 cycles after start.
5. ERR_CNT_WIDTH=4, ALU model returning flags 4'b0000 always, WIDTH=3 -> err_count saturates at 4'hF; first_err_a=0, first_err_b=0.
6. Abort at pair 20, and separately rst_n low mid-run -> abort: IDLE next cycle, no done, err_count retained. Reset: all outputs 0 immediately, asynchronously; a new start runs to normal completion.
